cd101_spi_master: RTL and testbench

SPI initiator that drives the configuration port (spi_nss, spi_mosi, spi_clk) of the cd101 core from a parallel request interface. It lives on the test/harness side of the link: it takes a FRAME_W-bit word via a valid/ready handshake and shifts it out MSB-first as one SPI mode-0 frame, so the slave samples on the spi_clk rising edge. It is write-only; the link has no MISO.

---
 rtl/cd101_spi_pkg.sv | 25 ++
 rtl/cd101_spi_master.sv | 86 ++++++++
 tb/tb_cd101_spi_master.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cd101_spi_pkg.sv
// Shared definitions for the cd101 configuration-port SPI initiator:
// frame geometry, FSM state encoding and a frame packing helper.
package cd101_spi_pkg;

   localparam int FRAME_W_DEF = 24;

   localparam int ADDR_MSB = 23;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} spi_state_e;

   function automatic logic [FRAME_W_DEF-1:0] frame_pack(
      input logic [ADDR_MSB-ADDR_LSB:0] addr,
      input logic [DATA_MSB-DATA_LSB:0] data
   );
      logic [FRAME_W_DEF-1:0] f;
      f = '0;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[DATA_MSB:DATA_LSB] = data;
      return f;
   endfunction

endpackage

// File: rtl/cd101_spi_master.sv
// Write-only SPI mode-0 initiator: takes one FRAME_W-bit word per valid/ready
// handshake and shifts it out MSB-first on spi_mosi under a low spi_nss.
module cd101_spi_master
   import cd101_spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int FRAME_W = FRAME_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               req_valid,
   input  logic [FRAME_W-1:0] req_data,
   output logic               req_ready,
   output logic               done,
   output logic               spi_nss,
   output logic               spi_mosi,
   output logic               spi_clk
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(FRAME_W);

   spi_state_e         state, nxt;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] shreg;
   logic               div_tc, last_bit, accept;

   assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit  = (bit_cnt == BIT_W'(FRAME_W - 1));
   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;
   // mosi is the shift-register MSB; the register is cleared outside a frame
   assign spi_mosi  = shreg[FRAME_W-1];

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req_valid) nxt = SETUP;
         SETUP:   if (div_tc)    nxt = HIGH;
         HIGH:    if (div_tc)    nxt = LOW;
         LOW:     if (div_tc)    nxt = last_bit ? GAP : HIGH;
         GAP:     if (div_tc)    nxt = IDLE;
         default:                nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         spi_nss <= 1'b1;
         spi_clk <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= nxt;
         done    <= 1'b0;
         // outputs follow the next state so they are registered with it
         spi_clk <= (nxt == HIGH);
         spi_nss <= (nxt == IDLE) || (nxt == GAP);
         if (state == IDLE || div_tc) div_cnt <= '0;
         else                         div_cnt <= div_cnt + DIV_W'(1);
         case (state)
            IDLE: if (accept) begin
               shreg   <= req_data;
               bit_cnt <= '0;
            end
            // advance on the falling spi_clk edge; the last bit is held
            HIGH: if (div_tc && !last_bit) shreg <= {shreg[FRAME_W-2:0], 1'b0};
            LOW: if (div_tc) begin
               if (last_bit) begin
                  bit_cnt <= '0;
                  shreg   <= '0;
                  done    <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cd101_spi_master.sv
// Bench for cd101_spi_master: a default instance and a CLK_DIV=1 instance,
// each with an SPI slave model feeding a scoreboard of expected frames.
module tb_cd101_spi_master;
   import cd101_spi_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rv   [2];
   logic [23:0] rd   [2];
   logic        rr   [2];
   logic        dn   [2];
   logic        nss  [2];
   logic        sck  [2];
   logic        mosi [2];

   logic [23:0] q0[$];
   logic [23:0] q1[$];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   cd101_spi_master u_dut0 (
      .clk(clk), .rstn(rstn), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
      .done(dn[0]), .spi_nss(nss[0]), .spi_mosi(mosi[0]), .spi_clk(sck[0]));

   cd101_spi_master #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
      .done(dn[1]), .spi_nss(nss[1]), .spi_mosi(mosi[1]), .spi_clk(sck[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic frame_end(input int idx, input logic [23:0] w, input int n);
      logic [23:0] e;
      if (idx == 0) begin
         if (q0.size() == 0) begin chk("unexpected_frame0", 32'd1, 32'd0); return; end
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) begin chk("unexpected_frame1", 32'd1, 32'd0); return; end
         e = q1.pop_front();
      end
      chk(idx == 0 ? "rx_word0" : "rx_word1", 32'(w), 32'(e));
      chk(idx == 0 ? "rx_rises0" : "rx_rises1", 32'(n), 32'd24);
   endtask

   // Slave model: samples mosi on each spi_clk rise while nss is low.
   for (genvar i = 0; i < 2; i++) begin : g_mon
      logic [23:0] cap;
      int          nr;
      initial forever begin
         @(negedge nss[i]);
         cap = '0;
         nr  = 0;
         forever begin
            @(posedge sck[i] or posedge nss[i]);
            if (nss[i]) break;
            cap = {cap[22:0], mosi[i]};
            nr++;
         end
         if (rstn) frame_end(i, cap, nr);
      end
      always @(posedge sck[i]) chk("sclk_in_frame", 32'(nss[i]), 32'd0);
   end

   // Caller sits just after a negedge. Returns at the negedge where ready is
   // seen again; with chain set, req_valid/nd are already driven there.
   task automatic send(input int idx, input int cd, input logic [23:0] d,
                       input bit scramble, input bit busy, input bit chain,
                       input logic [23:0] nd, input int chain_at, output int waits);
      int rel, low_n, hi_n, dn_n, done_rel, rise_rel, rdy_rel;
      rv[idx] = 1'b1;
      rd[idx] = d;
      waits   = 0;
      while (!rr[idx] && waits < 500) begin @(negedge clk); waits++; end
      if (!rr[idx]) begin chk("accept_timeout", 32'd0, 32'd1); rv[idx] = 1'b0; return; end
      if (idx == 0) q0.push_back(d); else q1.push_back(d);
      @(negedge clk);
      rel = 1; low_n = 0; hi_n = 0; dn_n = 0; done_rel = 0; rise_rel = 0; rdy_rel = 0;
      chk("nss_fall", 32'(nss[idx]), 32'd0);
      while (rel < 500) begin
         if (!nss[idx]) low_n++; else hi_n++;
         if (dn[idx]) begin dn_n++; if (done_rel == 0) done_rel = rel; end
         if (sck[idx] && rise_rel == 0) rise_rel = rel;
         if (rr[idx]) begin rdy_rel = rel; break; end
         if (busy && rel >= 20 && rel <= 22) chk("busy_no_accept", 32'(rr[idx]), 32'd0);
         rv[idx] = 1'b0;
         if (scramble) rd[idx] = 24'($urandom);
         if (busy && rel >= 19 && rel <= 21) begin rv[idx] = 1'b1; rd[idx] = ~d; end
         if (chain && rel >= chain_at) begin rv[idx] = 1'b1; rd[idx] = nd; end
         @(negedge clk);
         rel++;
      end
      if (rdy_rel == 0) chk("ready_timeout", 32'd0, 32'd1);
      chk("nss_low_cycles", 32'(low_n), 32'(cd * (1 + 2 * 24)));
      chk("first_rise", 32'(rise_rel), 32'(1 + cd));
      chk("done_at", 32'(done_rel), 32'(1 + cd * (1 + 2 * 24)));
      chk("done_pulses", 32'(dn_n), 32'd1);
      chk("ready_at", 32'(rdy_rel), 32'(1 + cd * (2 + 2 * 24)));
      // nss high from the first GAP cycle up to and including the IDLE cycle
      chk("nss_high_gap", 32'(hi_n), 32'(cd + 1));
   endtask

   initial begin
      int w;
      rstn = 1'b0;
      for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rd[i] = '0; end
      repeat (3) @(negedge clk);
      chk("in_reset", 32'({nss[0], sck[0], mosi[0], rr[0], dn[0]}), 32'(5'b10010));
      rstn = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("idle0", 32'({nss[0], sck[0], mosi[0], rr[0], dn[0]}), 32'(5'b10010));
         chk("idle1", 32'({nss[1], sck[1], mosi[1], rr[1], dn[1]}), 32'(5'b10010));
      end

      send(0, 4, 24'hA5C30F, 1'b0, 1'b0, 1'b0, '0, 0, w);

      send(1, 1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 24'h000000, 10, w);
      send(1, 1, 24'h000000, 1'b0, 1'b0, 1'b0, '0, 0, w);
      chk("b2b_accept_waits", 32'(w), 32'd0);

      send(0, 4, 24'h5A6B7C, 1'b1, 1'b0, 1'b0, '0, 0, w);

      send(0, 4, frame_pack(8'h3C, 16'hBEEF), 1'b0, 1'b1, 1'b1, 24'h0F0F0F, 40, w);
      send(0, 4, 24'h0F0F0F, 1'b0, 1'b0, 1'b0, '0, 0, w);
      chk("held_valid_waits", 32'(w), 32'd0);

      // Abort a frame while bit 11 is on the wire with spi_clk high.
      rv[0] = 1'b1;
      rd[0] = 24'hFFFFFF;
      chk("abort_ready", 32'(rr[0]), 32'd1);
      @(negedge clk);
      rv[0] = 1'b0;
      repeat (94) @(negedge clk);
      chk("pre_abort", 32'({nss[0], sck[0], mosi[0]}), 32'(3'b011));
      #1 rstn = 1'b0;
      #1 chk("rst_async", 32'({nss[0], sck[0], mosi[0], rr[0], dn[0]}), 32'(5'b10010));
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      send(0, 4, 24'h123456, 1'b0, 1'b0, 1'b0, '0, 0, w);

      repeat (10) @(negedge clk);
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule
